// File: rtl/button_click_decoder.sv
// Button click decoder.
// Groups debounced press pulses into single/double/triple click events. A click window stays
// open while presses keep arriving inside WINDOW_CYCLES. The event is offered on a
// valid/ready interface. Presses that arrive while an event is still pending are dropped and
// counted.

module button_click_decoder #(
  parameter logic [23:0] WINDOW_CYCLES = 24'd12500000,
  parameter int unsigned MAX_CLICKS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_i,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_clicks,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StHold
  } state_e;

  localparam logic [1:0]  MaxClicks = 2'(MAX_CLICKS);
  localparam logic [23:0] TimerLast = WINDOW_CYCLES - 24'd1;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [1:0]  clicks_q, clicks_d;
  logic [7:0]  drop_q, drop_d;
  logic [1:0]  clicks_inc;

  assign clicks_inc = clicks_q + 2'd1;

  // State registers. Reset is synchronous and overrides any press or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      clicks_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      clicks_q <= clicks_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state logic: window timing, click counting, event hand-off and drop counting.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    clicks_d = clicks_q;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        if (press_i) begin
          clicks_d = 2'd1;
          timer_d  = '0;
          // With a one-click limit, the first press is already a complete event.
          state_d  = (MaxClicks == 2'd1) ? StHold : StCount;
        end
      end

      StCount: begin
        if (press_i) begin
          // A press takes priority over a coincident timeout and restarts the window.
          clicks_d = clicks_inc;
          timer_d  = '0;
          if (clicks_inc == MaxClicks) begin
            state_d = StHold;
          end
        end else if (timer_q == TimerLast) begin
          timer_d = '0;
          state_d = StHold;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end

      StHold: begin
        // Presses during a pending event, including the handshake cycle, are discarded.
        if (press_i && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 8'd1;
        end
        if (evt_ready) begin
          state_d  = StIdle;
          clicks_d = '0;
          timer_d  = '0;
        end
      end

      default: begin
        state_d  = StIdle;
        timer_d  = '0;
        clicks_d = '0;
      end
    endcase
  end

  // Outputs depend only on registered state, so evt_valid never depends on evt_ready.
  always_comb begin
    evt_valid  = (state_q == StHold);
    evt_clicks = evt_valid ? clicks_q : 2'd0;
    busy       = (state_q != StIdle);
    drop_cnt   = drop_q;
  end

endmodule

// File: tb/tb_button_click_decoder.sv
// Bench for button_click_decoder: two instances (three-click and one-click limit) share the
// stimulus, and both are compared every cycle against an event-level reference model.

module tb_button_click_decoder;

  localparam int Win = 10;

  logic       clk = 1'b0;
  logic       rst, press, ready;
  logic       v0, b0, v1, b1;
  logic [1:0] c0, c1;
  logic [7:0] d0, d1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    bit pend;
    bit open;
    int clicks;
    int deadline;  // absolute cycle at which a timed-out event becomes visible
    int drops;
  } model_t;

  model_t m3, m1;

  always #5 clk = ~clk;

  button_click_decoder #(
    .WINDOW_CYCLES(24'd10),
    .MAX_CLICKS   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .press_i   (press),
    .evt_ready (ready),
    .evt_valid (v0),
    .evt_clicks(c0),
    .busy      (b0),
    .drop_cnt  (d0)
  );

  button_click_decoder #(
    .WINDOW_CYCLES(24'd10),
    .MAX_CLICKS   (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .press_i   (press),
    .evt_ready (ready),
    .evt_valid (v1),
    .evt_clicks(c1),
    .busy      (b1),
    .drop_cnt  (d1)
  );

  // Reference: what the outputs should be in cycle c+1 given inputs sampled in cycle c.
  function automatic model_t upd(model_t m, int c, bit p, bit r, bit rs, int mx);
    model_t n = m;
    if (rs) begin
      n = '0;
    end else if (m.pend) begin
      if (p && n.drops < 255) n.drops = n.drops + 1;
      if (r) begin
        n.pend   = 1'b0;
        n.clicks = 0;
      end
    end else if (m.open) begin
      if (p) begin
        n.clicks = n.clicks + 1;
        if (n.clicks == mx) begin
          n.open = 1'b0;
          n.pend = 1'b1;
        end else begin
          n.deadline = c + 1 + Win;
        end
      end else if (c + 1 == m.deadline) begin
        n.open = 1'b0;
        n.pend = 1'b1;
      end
    end else if (p) begin
      n.clicks = 1;
      if (mx == 1) begin
        n.pend = 1'b1;
      end else begin
        n.open     = 1'b1;
        n.deadline = c + 1 + Win;
      end
    end
    return n;
  endfunction

  task automatic chk1(input string tag, input logic v, input logic [1:0] c, input logic b,
                      input logic [7:0] d, input model_t m);
    logic       ev;
    logic [1:0] ec;
    logic       eb;
    logic [7:0] ed;
    ev = m.pend;
    ec = m.pend ? 2'(m.clicks) : 2'd0;
    eb = m.pend || m.open;
    ed = 8'(m.drops);
    total++;
    assert (v === ev) else begin
      bad++;
      $error("FAIL %s evt_valid cyc=%0d got %b want %b", tag, cyc, v, ev);
    end
    total++;
    assert (c === ec) else begin
      bad++;
      $error("FAIL %s evt_clicks cyc=%0d got %0d want %0d", tag, cyc, c, ec);
    end
    total++;
    assert (b === eb) else begin
      bad++;
      $error("FAIL %s busy cyc=%0d got %b want %b", tag, cyc, b, eb);
    end
    total++;
    assert (d === ed) else begin
      bad++;
      $error("FAIL %s drop_cnt cyc=%0d got %0d want %0d", tag, cyc, d, ed);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input bit p, input bit r, input bit rs);
    press = p;
    ready = r;
    rst   = rs;
    @(posedge clk);
    m3 = upd(m3, cyc, p, r, rs, 3);
    m1 = upd(m1, cyc, p, r, rs, 1);
    cyc++;
    @(negedge clk);
    chk1("max3", v0, c0, b0, d0, m3);
    chk1("max1", v1, c1, b1, d1, m1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, r, 1'b0);
  endtask

  initial begin
    int pp;
    int rp;
    rst   = 1'b1;
    press = 1'b0;
    ready = 1'b0;
    m3    = '0;
    m1    = '0;
    @(negedge clk);

    // Reset, then quiet cycles with ready toggling: outputs must stay at reset values.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    idle(2, 1'b0);

    // Single press, timeout event.
    step(1'b1, 1'b1, 1'b0);
    idle(14, 1'b1);

    // Presses at 0 and 5: double click after timeout.
    step(1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(14, 1'b1);

    // Presses at 0, 3, 6: triple click without waiting.
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Press coinciding with the last window cycle is counted and restarts the window.
    step(1'b1, 1'b1, 1'b0);
    idle(9, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(14, 1'b1);

    // Pending event held for 300 cycles under a press storm: drop counter saturates.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Reset while counting (two clicks) and while holding: nothing is emitted.
    step(1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(12, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(13, 1'b1);

    // Randomised traffic with varying press density, back-pressure and rare resets.
    for (int blk = 0; blk < 20; blk++) begin
      pp = $urandom_range(2, 25);
      rp = $urandom_range(1, 10);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(1, pp) == 1), ($urandom_range(1, 10) <= rp),
             ($urandom_range(0, 299) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_click_decoder.md
BUTTON_CLICK_DECODER -- requirements
Module: button_click_decoder

Interface
REQ-001 The block SHALL have parameter WINDOW_CYCLES, default 24'd12500000, inter-click window in clk cycles (250 ms at 50 MHz), legal range 2..2^24-1.
REQ-002 The block SHALL have parameter MAX_CLICKS, default 3, click count at which an event is emitted immediately, legal range 1..3.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port press_i, input, 1, one-cycle debounced press-complete pulse from the upstream debouncer.
REQ-006 The block SHALL have port evt_ready, input, 1, consumer accepts event.
REQ-007 The block SHALL have port evt_valid, output, 1, click event available.
REQ-008 The block SHALL have port evt_clicks, output, 2, click count of the event (1..MAX_CLICKS).
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port drop_cnt, output, 8, saturating count of press_i pulses discarded while an event is pending.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, COUNT (window open), HOLD (event pending).
REQ-012 In IDLE, press_i SHALL move to COUNT next cycle with clicks=1, timer=0; if MAX_CLICKS==1 it SHALL instead move directly to HOLD with evt_clicks=1.
REQ-013 In COUNT, the 24-bit timer SHALL increment by 1 each cycle without press_i.
REQ-014 In COUNT, press_i SHALL clear timer to 0 and increment clicks; if the new count equals MAX_CLICKS the FSM SHALL go to HOLD next cycle.
REQ-015 In COUNT, timer == WINDOW_CYCLES-1 with no press_i SHALL move to HOLD next cycle with evt_clicks = current clicks.
REQ-016 Press_i and timeout in the same cycle: press SHALL win (counted, timer cleared, window restarts unless MAX_CLICKS reached).
REQ-017 In HOLD, evt_valid SHALL be 1 and evt_clicks SHALL remain stable until the handshake.
REQ-018 Handshake occurs on a cycle with evt_valid && evt_ready; the FSM SHALL return to IDLE and evt_valid SHALL be 0 the following cycle.
REQ-019 evt_valid SHALL never depend combinationally on evt_ready; evt_ready outside HOLD SHALL be ignored.
REQ-020 press_i in HOLD, including the handshake cycle, SHALL be discarded and SHALL increment drop_cnt, saturating at 8'hFF.
REQ-021 evt_clicks SHALL be 0 whenever evt_valid is 0.
REQ-022 busy SHALL be registered-state derived: 1 in COUNT and HOLD, 0 in IDLE.
REQ-023 Event latency: evt_valid SHALL assert exactly WINDOW_CYCLES cycles after the cycle following the last counted press_i (timeout case), or 1 cycle after the press reaching MAX_CLICKS.

Reset
REQ-024 On rst high at a clock edge, state SHALL become IDLE, timer and clicks 0, evt_valid 0, evt_clicks 0, busy 0, drop_cnt 0.
REQ-025 rst SHALL take priority over press_i and evt_ready in the same cycle; a pending event or open window SHALL be discarded without output.
REQ-026 No output SHALL change from its reset value until the first press_i after rst deasserts.

Verification (WINDOW_CYCLES=10, MAX_CLICKS=3 unless stated)
REQ-027 Single press at cycle 0, evt_ready=1 -> evt_valid high for exactly one cycle at cycle 11, evt_clicks=1, then busy=0.
REQ-028 Presses at cycles 0 and 5 -> evt_valid at cycle 16 with evt_clicks=2; press at cycle 9 of a window with timeout coincident -> counted, window restarts.
REQ-029 Presses at cycles 0, 3, 6 -> evt_valid at cycle 7 with evt_clicks=3, no timeout wait.
REQ-030 Event pending with evt_ready=0 for 300 cycles and 300 press_i pulses -> evt_clicks stable, drop_cnt=8'hFF, evt_ready then -> IDLE next cycle.
REQ-031 rst pulsed while in COUNT (clicks=2) and again while in HOLD -> no evt_valid emitted, all outputs zero, next single press yields evt_clicks=1.
REQ-032 MAX_CLICKS=1: press at cycle 0 -> evt_valid at cycle 1, evt_clicks=1, COUNT never entered.
